// File: rtl/aes_pkg.sv
// Shared AES core types: job ownership, scheduler states and the byte widths
// of a full cipher state and of a single key-schedule word.
package aes_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_D,
    OWN_K
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam int unsigned AES_STATE_BYTES = 16;
  localparam int unsigned AES_WORD_BYTES  = 4;

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, table based.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign d = Sbox[a];

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares one external S-box between SubBytes (D) and SubWord (K) jobs, one byte
// per cycle, with round-robin arbitration on ties and a held response per job.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int unsigned DATA_BYTES = AES_STATE_BYTES,
  parameter int unsigned KEY_BYTES  = AES_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [8*DATA_BYTES-1:0] d_req_data,
  output logic                    d_rsp_valid,
  input  logic                    d_rsp_ready,
  output logic [8*DATA_BYTES-1:0] d_rsp_data,
  input  logic                    k_req_valid,
  output logic                    k_req_ready,
  input  logic [8*KEY_BYTES-1:0]  k_req_data,
  output logic                    k_rsp_valid,
  input  logic                    k_rsp_ready,
  output logic [8*KEY_BYTES-1:0]  k_rsp_data,
  output logic [7:0]              sbox_a,
  input  logic [7:0]              sbox_d
);

  localparam int unsigned MaxBytes = (DATA_BYTES > KEY_BYTES) ? DATA_BYTES : KEY_BYTES;
  localparam int unsigned CntW     = (MaxBytes > 1) ? $clog2(MaxBytes) : 1;
  localparam int unsigned JobW     = 8 * MaxBytes;
  localparam logic [CntW-1:0] DLast = CntW'(DATA_BYTES - 1);
  localparam logic [CntW-1:0] KLast = CntW'(KEY_BYTES - 1);

  state_e                  state_q, state_d;
  owner_e                  owner_q, last_grant_q;
  logic [CntW-1:0]         cnt_q;
  logic [JobW-1:0]         job_q;
  logic [8*DATA_BYTES-1:0] d_data_q;
  logic [8*KEY_BYTES-1:0]  k_data_q;
  logic                    d_valid_q, k_valid_q;
  logic                    grant_d, grant_k;
  logic                    job_done, rsp_take;

  assign job_done = (state_q == ST_RUN) && (cnt_q == ((owner_q == OWN_D) ? DLast : KLast));
  assign rsp_take = (state_q == ST_HOLD) && ((owner_q == OWN_D) ? d_rsp_ready : k_rsp_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_d || grant_k) state_d = ST_RUN;
      ST_RUN:  if (job_done) state_d = ST_HOLD;
      ST_HOLD: if (rsp_take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants exist only in IDLE; on a tie the requester not served last wins.
  always_comb begin
    grant_d = 1'b0;
    grant_k = 1'b0;
    sbox_a  = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req_valid && k_req_valid) begin
          grant_k = (last_grant_q == OWN_D);
          grant_d = (last_grant_q != OWN_D);
        end else begin
          grant_d = d_req_valid;
          grant_k = k_req_valid;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < MaxBytes; i++) begin
          if (cnt_q == CntW'(i)) sbox_a = job_q[8*i +: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      last_grant_q <= OWN_D;
      cnt_q        <= '0;
      job_q        <= '0;
      d_data_q     <= '0;
      k_data_q     <= '0;
      d_valid_q    <= 1'b0;
      k_valid_q    <= 1'b0;
    end else begin
      if (grant_d || grant_k) begin
        owner_q      <= grant_d ? OWN_D : OWN_K;
        last_grant_q <= grant_d ? OWN_D : OWN_K;
        cnt_q        <= '0;
        job_q        <= grant_d ? JobW'(d_req_data) : JobW'(k_req_data);
      end
      if (state_q == ST_RUN) begin
        if (owner_q == OWN_D) begin
          for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (cnt_q == CntW'(i)) d_data_q[8*i +: 8] <= sbox_d;
          end
        end else begin
          for (int unsigned i = 0; i < KEY_BYTES; i++) begin
            if (cnt_q == CntW'(i)) k_data_q[8*i +: 8] <= sbox_d;
          end
        end
        cnt_q <= job_done ? '0 : cnt_q + CntW'(1);
        if (job_done) begin
          d_valid_q <= (owner_q == OWN_D);
          k_valid_q <= (owner_q == OWN_K);
        end
      end
      if (rsp_take) begin
        d_valid_q <= 1'b0;
        k_valid_q <= 1'b0;
        owner_q   <= OWN_NONE;
      end
    end
  end

  assign d_req_ready = grant_d;
  assign k_req_ready = grant_k;
  assign d_rsp_valid = d_valid_q;
  assign k_rsp_valid = k_valid_q;
  assign d_rsp_data  = d_data_q;
  assign k_rsp_data  = k_data_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched driving the real aes_sbox; expected bytes
// come from an independent copy of the FIPS-197 table.
module tb_aes_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         d_req_valid = 1'b0, d_req_ready, d_rsp_valid, d_rsp_ready = 1'b0;
  logic [127:0] d_req_data = '0, d_rsp_data;
  logic         k_req_valid = 1'b0, k_req_ready, k_rsp_valid, k_rsp_ready = 1'b0;
  logic [31:0]  k_req_data = '0, k_rsp_data;
  logic [7:0]   sbox_a, sbox_d;

  int n_checks = 0;
  int n_fail   = 0;

  aes_sbox_sched #(.DATA_BYTES(16), .KEY_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_data(d_req_data),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .k_req_valid(k_req_valid), .k_req_ready(k_req_ready), .k_req_data(k_req_data),
    .k_rsp_valid(k_rsp_valid), .k_rsp_ready(k_rsp_ready), .k_rsp_data(k_rsp_data),
    .sbox_a(sbox_a), .sbox_d(sbox_d)
  );

  aes_sbox u_sbox (.a(sbox_a), .d(sbox_d));

  always #5 clk = ~clk;

  logic [7:0] ref_tbl [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [127:0] sub_d(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tbl[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_k(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_tbl[x[8*i +: 8]];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    d_req_valid = 1'b0; k_req_valid = 1'b0; d_rsp_ready = 1'b0; k_rsp_ready = 1'b0;
    d_req_data = '0; k_req_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs one D job with rsp_ready=1; lat = edges from handshake to rsp_valid, -1 on timeout.
  task automatic run_d_job(input logic [127:0] data, output logic [127:0] res, output int lat);
    int w;
    lat = -1; res = '0; w = 0;
    @(negedge clk);
    d_req_data = data; d_req_valid = 1'b1; d_rsp_ready = 1'b1;
    #1;
    while (!d_req_ready && w < 100) begin @(negedge clk); #1; w++; end
    if (!d_req_ready) begin d_req_valid = 1'b0; return; end
    @(posedge clk);
    #1 d_req_valid = 1'b0; d_req_data = ~data;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_rsp_valid) begin lat = k; res = d_rsp_data; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_k_job(input logic [31:0] data, output logic [31:0] res, output int lat);
    int w;
    lat = -1; res = '0; w = 0;
    @(negedge clk);
    k_req_data = data; k_req_valid = 1'b1; k_rsp_ready = 1'b1;
    #1;
    while (!k_req_ready && w < 100) begin @(negedge clk); #1; w++; end
    if (!k_req_ready) begin k_req_valid = 1'b0; return; end
    @(posedge clk);
    #1 k_req_valid = 1'b0; k_req_data = ~data;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k_rsp_valid) begin lat = k; res = k_rsp_data; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b0 || k_req_ready !== 1'b0) begin
      $display("FAIL reset_ready: d=%b k=%b, required 0 0", d_req_ready, k_req_ready); n_fail++;
    end
    n_checks++;
    if (d_rsp_valid !== 1'b0 || k_rsp_valid !== 1'b0) begin
      $display("FAIL reset_rsp_valid: d=%b k=%b, required 0 0", d_rsp_valid, k_rsp_valid); n_fail++;
    end
    n_checks++;
    if (d_rsp_data !== 128'h0 || k_rsp_data !== 32'h0) begin
      $display("FAIL reset_rsp_data: d=%h k=%h, required 0", d_rsp_data, k_rsp_data); n_fail++;
    end
    n_checks++;
    if (sbox_a !== 8'h00) begin
      $display("FAIL reset_sbox_a: got %h, required 00", sbox_a); n_fail++;
    end
  endtask

  task automatic test_tie();
    logic [127:0] dd;
    logic [31:0]  kd;
    int           g_who [3];
    int           g_cyc [3];
    int           ng;
    dd = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    kd = 32'hc0ffee42;
    ng = 0;
    do_reset();
    @(negedge clk);
    d_req_data = dd; k_req_data = kd;
    d_req_valid = 1'b1; k_req_valid = 1'b1; d_rsp_ready = 1'b1; k_rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (d_req_ready && k_req_ready) begin
        n_checks++; n_fail++;
        $display("FAIL tie_both_ready: cycle %0d both readies high, required one", c);
      end
      if (k_req_ready) begin g_who[ng] = 2; g_cyc[ng] = c; ng++; end
      else if (d_req_ready) begin g_who[ng] = 1; g_cyc[ng] = c; ng++; end
      if (ng == 3) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 d_req_valid = 1'b0; k_req_valid = 1'b0;
    n_checks++;
    if (ng != 3) begin
      $display("FAIL tie_grant_count: got %0d grants, required 3", ng); n_fail++;
    end else begin
      n_checks++;
      if (g_who[0] != 2 || g_who[1] != 1 || g_who[2] != 2) begin
        $display("FAIL tie_order: got %0d,%0d,%0d, required 2,1,2 (1=D 2=K)",
                 g_who[0], g_who[1], g_who[2]); n_fail++;
      end
      n_checks++;
      if (g_cyc[0] != 0 || g_cyc[1] != 6 || g_cyc[2] != 24) begin
        $display("FAIL tie_timing: grant cycles %0d,%0d,%0d, required 0,6,24",
                 g_cyc[0], g_cyc[1], g_cyc[2]); n_fail++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k_rsp_valid) break;
    end
    n_checks++;
    if (k_rsp_valid !== 1'b1 || k_rsp_data !== sub_k(kd)) begin
      $display("FAIL tie_k_result: valid=%b data=%h, required 1 %h", k_rsp_valid, k_rsp_data,
               sub_k(kd)); n_fail++;
    end
    n_checks++;
    if (d_rsp_data !== sub_d(dd)) begin
      $display("FAIL tie_d_result_kept: got %h, required %h", d_rsp_data, sub_d(dd)); n_fail++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_d_zero();
    logic [127:0] res;
    int           lat;
    run_d_job(128'h0, res, lat);
    n_checks++;
    if (lat != 16) begin
      $display("FAIL d_zero_latency: got %0d, required 16", lat); n_fail++;
    end
    n_checks++;
    if (res !== {16{8'h63}}) begin
      $display("FAIL d_zero_data: got %h, required %h", res, {16{8'h63}}); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d_rsp_valid !== 1'b0) begin
      $display("FAIL d_zero_single_cycle: d_rsp_valid=%b, required 0", d_rsp_valid); n_fail++;
    end
  endtask

  task automatic test_key();
    logic [7:0] exp_a [4];
    exp_a = '{8'h00, 8'h53, 8'hff, 8'h01};
    @(negedge clk);
    k_req_data = 32'h01ff5300; k_req_valid = 1'b1; k_rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (k_req_ready !== 1'b1) begin
      $display("FAIL key_ready: got %b, required 1", k_req_ready); n_fail++;
    end
    @(posedge clk);
    #1 k_req_valid = 1'b0; k_req_data = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (sbox_a !== exp_a[i]) begin
        $display("FAIL key_sbox_a_trace[%0d]: got %h, required %h", i, sbox_a, exp_a[i]); n_fail++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (k_rsp_valid !== 1'b1 || k_rsp_data !== 32'h7c16ed63 || sbox_a !== 8'h00) begin
      $display("FAIL key_result: valid=%b data=%h sbox_a=%h, required 1 7c16ed63 00",
               k_rsp_valid, k_rsp_data, sbox_a); n_fail++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [31:0]  kd;
    logic [127:0] dd;
    int           c;
    kd = 32'h11223344;
    dd = 128'hffeeddccbbaa99887766554433221100;
    @(negedge clk);
    k_req_data = kd; k_req_valid = 1'b1; k_rsp_ready = 1'b0; d_rsp_ready = 1'b1;
    @(posedge clk);
    #1 k_req_valid = 1'b0; d_req_valid = 1'b1; d_req_data = dd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k_rsp_valid) break;
    end
    n_checks++;
    if (k_rsp_valid !== 1'b1) begin
      $display("FAIL bp_k_valid_timeout: k_rsp_valid=%b, required 1", k_rsp_valid); n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (k_rsp_valid !== 1'b1 || k_rsp_data !== sub_k(kd) || d_req_ready !== 1'b0 ||
          sbox_a !== 8'h00) begin
        $display("FAIL bp_hold[%0d]: kv=%b kdata=%h d_ready=%b sbox_a=%h, required 1 %h 0 00",
                 i, k_rsp_valid, k_rsp_data, d_req_ready, sbox_a, sub_k(kd)); n_fail++;
      end
    end
    k_rsp_ready = 1'b1;
    @(posedge clk);
    #1 k_rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (d_req_ready !== 1'b1 || k_rsp_valid !== 1'b0) begin
      $display("FAIL bp_release_grant: d_ready=%b k_valid=%b, required 1 0",
               d_req_ready, k_rsp_valid); n_fail++;
    end
    @(posedge clk);
    #1 d_req_valid = 1'b0; d_req_data = '0;
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (d_rsp_valid) break;
      c++;
    end
    n_checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== sub_d(dd)) begin
      $display("FAIL bp_d_result: valid=%b data=%h, required 1 %h", d_rsp_valid, d_rsp_data,
               sub_d(dd)); n_fail++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] dd, res;
    int           lat;
    for (int i = 0; i < 16; i++) dd[8*i +: 8] = 8'(8'h30 + i);
    @(negedge clk);
    d_req_data = dd; d_req_valid = 1'b1; d_rsp_ready = 1'b1;
    @(posedge clk);
    #1 d_req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (sbox_a !== 8'h37) begin
      $display("FAIL rst_mid_sbox_a_cnt7: got %h, required 37", sbox_a); n_fail++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_rsp_valid !== 1'b0 || sbox_a !== 8'h00 || d_rsp_data !== 128'h0) begin
      $display("FAIL rst_mid_state: d_valid=%b sbox_a=%h d_data=%h, required 0 00 0",
               d_rsp_valid, sbox_a, d_rsp_data); n_fail++;
    end
    d_req_valid = 1'b1;
    #1;
    n_checks++;
    if (d_req_ready !== 1'b1) begin
      $display("FAIL rst_mid_idle: d_req_ready=%b, required 1", d_req_ready); n_fail++;
    end
    d_req_valid = 1'b0;
    run_d_job(~dd, res, lat);
    n_checks++;
    if (lat != 16 || res !== sub_d(~dd)) begin
      $display("FAIL rst_mid_next_job: lat=%0d data=%h, required 16 %h", lat, res, sub_d(~dd));
      n_fail++;
    end
  endtask

  task automatic test_exhaustive();
    logic [127:0] dd, dres;
    logic [31:0]  kd, kres;
    int           lat;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) dd[8*i +: 8] = 8'(16 * j + i);
      run_d_job(dd, dres, lat);
      n_checks++;
      if (lat != 16 || dres !== sub_d(dd)) begin
        $display("FAIL exh_d[%0d]: lat=%0d data=%h, required 16 %h", j, lat, dres, sub_d(dd));
        n_fail++;
      end
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < 4; i++) kd[8*i +: 8] = 8'(4 * (4 * j + m) + i);
        run_k_job(kd, kres, lat);
        n_checks++;
        if (lat != 4 || kres !== sub_k(kd)) begin
          $display("FAIL exh_k[%0d]: lat=%0d data=%h, required 4 %h", 4 * j + m, lat, kres,
                   sub_k(kd)); n_fail++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tie();
    test_d_zero();
    test_key();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
